// File: rtl/find_first_one_index_core.sv
// -----------------------------------------------------------------------------
// find_first_one_index_core
//
// Parameterised priority encoder. Reports the position of the lowest-indexed
// set bit of vector_in, together with a flag saying whether any bit is set.
// Bit 0 has the highest priority. When no bit is set, the index reads 0 and the
// found flag reads 0, so index 0 is only meaningful together with the flag.
//
// Parameters
//   VECTOR_LENGTH     width of vector_in (1 .. 2^MAX_OUTPUT_WIDTH)
//   MAX_OUTPUT_WIDTH  width of first_one_index_out; the index is zero-extended
//
// Ports
//   clk_in               in   1                 rising-edge clock
//   reset_in             in   1                 synchronous, active-high reset
//   vector_in            in   VECTOR_LENGTH     vector to scan, bit 0 first
//   first_one_index_out  out  MAX_OUTPUT_WIDTH  index of lowest set bit
//   one_is_found_out     out  1                 1 when any bit of vector_in is set
//
// Configuration macro
//   FIND_FIRST_ONE_INDEX_COMB_BYPASS_EN
//     undefined (default): outputs registered, one cycle latency, reset clears
//                          both outputs and has priority over the new encode.
//     defined:             outputs purely combinational from vector_in; clock
//                          and reset are unused and no flops are inferred.
//   The encode itself is identical in both builds.
// -----------------------------------------------------------------------------
module find_first_one_index_core #(
  parameter int VECTOR_LENGTH    = 8,
  parameter int MAX_OUTPUT_WIDTH = 32
) (
  input  logic                        clk_in,
  input  logic                        reset_in,
  input  logic [VECTOR_LENGTH-1:0]    vector_in,
  output logic [MAX_OUTPUT_WIDTH-1:0] first_one_index_out,
  output logic                        one_is_found_out
);

  // Width of the natural (unextended) index. A one-bit vector still needs a
  // one-bit index field so that the arithmetic below stays well-formed; that
  // bit is always 0.
  localparam int INDEX_WIDTH = (VECTOR_LENGTH > 1) ? $clog2(VECTOR_LENGTH) : 1;

  // Elaboration-time sanity checks on the parameter set.
  generate
    if (VECTOR_LENGTH < 1) begin : g_bad_length
      $error("find_first_one_index_core: VECTOR_LENGTH must be at least 1");
    end
    if (MAX_OUTPUT_WIDTH < INDEX_WIDTH) begin : g_bad_width
      $error("find_first_one_index_core: MAX_OUTPUT_WIDTH too small for VECTOR_LENGTH");
    end
  endgenerate

  // Encode result bundle shared by both builds.
  typedef struct packed {
    logic [INDEX_WIDTH-1:0] index;
    logic                   found;
  } encode_t;

  // Lowest-set-bit encoder. The scan latches on the first hit so later (higher)
  // bits cannot overwrite it; an all-zero vector leaves index 0 / found 0.
  function automatic encode_t encode_first_one(input logic [VECTOR_LENGTH-1:0] vec);
    encode_t result;
    result.index = {INDEX_WIDTH{1'b0}};
    result.found = 1'b0;
    for (int i = 0; i < VECTOR_LENGTH; i++) begin
      if (!result.found && vec[i]) begin
        result.index = INDEX_WIDTH'(i);
        result.found = 1'b1;
      end else begin
        result.index = result.index;
        result.found = result.found;
      end
    end
    return result;
  endfunction

  encode_t                     encode_now;
  logic [MAX_OUTPUT_WIDTH-1:0] index_extended;

  // Combinational encode of the present input vector.
  always_comb begin
    encode_now = encode_first_one(vector_in);
  end

  // Zero-extend the natural index to the output width.
  assign index_extended = MAX_OUTPUT_WIDTH'(encode_now.index);

`ifdef FIND_FIRST_ONE_INDEX_COMB_BYPASS_EN

  // Zero-latency build: clock and reset are deliberately ignored.
  logic unused_clk_reset;
  assign unused_clk_reset = clk_in ^ reset_in;

  assign first_one_index_out = index_extended;
  assign one_is_found_out    = encode_now.found;

`else

  // Registered outputs; reset wins over the encode taken on the same edge.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      first_one_index_out <= {MAX_OUTPUT_WIDTH{1'b0}};
      one_is_found_out    <= 1'b0;
    end else begin
      first_one_index_out <= index_extended;
      one_is_found_out    <= encode_now.found;
    end
  end

`endif

endmodule

// File: tb/tb_find_first_one_index_core.sv
// -----------------------------------------------------------------------------
// Bench for find_first_one_index_core (default registered build, 8-bit vector,
// 32-bit index). A driver applies one directed vector per cycle on the falling
// edge and queues the hand-computed response; a monitor pops one expectation
// after each rising edge and compares it against the outputs.
// -----------------------------------------------------------------------------
module tb_find_first_one_index_core;

  localparam int VL = 8;
  localparam int OW = 32;

  logic          clk_in;
  logic          reset_in;
  logic [VL-1:0] vector_in;
  logic [OW-1:0] first_one_index_out;
  logic          one_is_found_out;

  find_first_one_index_core #(
    .VECTOR_LENGTH   (VL),
    .MAX_OUTPUT_WIDTH(OW)
  ) dut (
    .clk_in             (clk_in),
    .reset_in           (reset_in),
    .vector_in          (vector_in),
    .first_one_index_out(first_one_index_out),
    .one_is_found_out   (one_is_found_out)
  );

  typedef struct packed {
    logic [OW-1:0] index;
    logic          found;
    logic [VL-1:0] vec;
    logic          rst;
  } expect_t;

  typedef struct packed {
    logic          rst;
    logic [VL-1:0] vec;
    logic [OW-1:0] index;
    logic          found;
  } step_t;

  expect_t exp_q[$];
  int      compared   = 0;
  int      mismatched = 0;

  // Directed stimulus table with hand-computed results.
  localparam int NSTEPS = 18;
  step_t steps [NSTEPS];

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  // Monitor: one expectation is due after every rising edge that followed a push.
  initial begin
    expect_t e;
    forever begin
      @(posedge clk_in);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        compared++;
        if (first_one_index_out !== e.index) begin
          mismatched++;
          $display("FAIL index vec=%h rst=%0b: got %0d (0x%h) expected %0d (0x%h)",
                   e.vec, e.rst, first_one_index_out, first_one_index_out, e.index, e.index);
        end
        compared++;
        if (one_is_found_out !== e.found) begin
          mismatched++;
          $display("FAIL found vec=%h rst=%0b: got %0b expected %0b",
                   e.vec, e.rst, one_is_found_out, e.found);
        end
      end
    end
  end

  // Driver: fill the table, then apply one step per falling edge.
  initial begin
    int waited;
    //              rst   vector  index   found
    steps[0]  = '{1'b1, 8'h00, 32'd0, 1'b0};  // reset held
    steps[1]  = '{1'b1, 8'hFF, 32'd0, 1'b0};  // reset beats a busy vector
    steps[2]  = '{1'b0, 8'h00, 32'd0, 1'b0};  // all zero
    steps[3]  = '{1'b0, 8'h01, 32'd0, 1'b1};  // bit 0
    steps[4]  = '{1'b0, 8'h10, 32'd4, 1'b1};  // bit 4
    steps[5]  = '{1'b0, 8'h80, 32'd7, 1'b1};  // top bit
    steps[6]  = '{1'b0, 8'hA0, 32'd5, 1'b1};  // bits 5,7 -> 5
    steps[7]  = '{1'b0, 8'hFF, 32'd0, 1'b1};  // all set -> 0
    steps[8]  = '{1'b0, 8'h02, 32'd1, 1'b1};
    steps[9]  = '{1'b0, 8'h0C, 32'd2, 1'b1};  // bits 2,3 -> 2
    steps[10] = '{1'b0, 8'h60, 32'd5, 1'b1};  // bits 5,6 -> 5
    steps[11] = '{1'b0, 8'hC0, 32'd6, 1'b1};  // bits 6,7 -> 6
    steps[12] = '{1'b0, 8'h00, 32'd0, 1'b0};  // back to zero
    steps[13] = '{1'b0, 8'h10, 32'd4, 1'b1};
    steps[14] = '{1'b1, 8'h80, 32'd0, 1'b0};  // mid-stream reset
    steps[15] = '{1'b0, 8'h80, 32'd7, 1'b1};  // first result after reset
    steps[16] = '{1'b0, 8'h48, 32'd3, 1'b1};  // bits 3,6 -> 3
    steps[17] = '{1'b0, 8'h00, 32'd0, 1'b0};

    reset_in  = 1'b1;
    vector_in = 8'h00;

    for (int s = 0; s < NSTEPS; s++) begin
      @(negedge clk_in);
      reset_in  = steps[s].rst;
      vector_in = steps[s].vec;
      exp_q.push_back('{index: steps[s].index, found: steps[s].found,
                        vec: steps[s].vec, rst: steps[s].rst});
    end

    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      @(negedge clk_in);
      waited++;
    end
    if (exp_q.size() > 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: %0d results still pending, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
